pattern_scan_array: RTL and testbench
=====================================

PATTERN_SCAN_ARRAY -- requirements
Module: pattern_scan_array

Interface
REQ-001 Parameters SHALL be: DWIDTH, 8, character width; PAT_MAX, 16, max pattern length (>=2); POS_W, 16, text position/count width; WILDCARD, 8'h3F, don't-care character code.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-low reset
  abort  in  1  synchronous clear to IDLE
  wildcard_en  in  1  enables WILDCARD don't-care matching
  pat_valid  in  1  pattern char valid
  pat_ready  out  1  pattern char accepted
  pat_char  in  DWIDTH  pattern character
  pat_last  in  1  final pattern character
  txt_valid  in  1  text char valid
  txt_ready  out  1  text char accepted
  txt_char  in  DWIDTH  text character
  txt_last  in  1  final text character
  match_valid  out  1  one-cycle match pulse
  match_pos  out  POS_W  0-based text index of last char of match
  match_count  out  POS_W  matches found in current scan
  pat_err  out  1  sticky: pattern exceeded PAT_MAX
  busy  out  1  state is not IDLE
  done  out  1  one-cycle end-of-scan pulse

Function
REQ-003 FSM SHALL have states IDLE, LOAD, SCAN, DONE.
REQ-004 pat_ready SHALL be 1 in IDLE and LOAD only; txt_ready SHALL be 1 in SCAN only; data offered while not ready SHALL be ignored.
REQ-005 A pattern handshake (pat_valid & pat_ready) SHALL store pat_char at index pat_len and increment pat_len; IDLE moves to LOAD on first handshake.
REQ-006 Handshake with pat_last SHALL move to SCAN next edge; wildcard_en SHALL be sampled on that handshake and held through the scan.
REQ-007 Pattern chars beyond PAT_MAX SHALL be dropped, pat_len SHALL saturate at PAT_MAX, pat_err SHALL set and hold until next IDLE->LOAD transition.
REQ-008 Per text handshake, eq[i] = (i<pat_len) & ((pat[i]==txt_char) | (wildcard_en & pat[i]==WILDCARD)); state vector D SHALL update to ((D<<1)|1) & eq (shift-and).
REQ-009 If updated D[pat_len-1]==1, match_valid SHALL pulse high on the cycle after the handshake (latency 1) with match_pos = index of that text char.
REQ-010 Overlapping matches SHALL each be reported; back-to-back matches SHALL give consecutive match_valid pulses.
REQ-011 Text position counter and match_count SHALL start at 0 on SCAN entry and saturate at 2^POS_W-1 (no wrap); match_count SHALL update on the same cycle as match_valid.
REQ-012 Handshake with txt_last SHALL be fully evaluated (match reported if any) and move to DONE; DONE SHALL assert done for one cycle then go to IDLE, keeping match_count until next SCAN entry.
REQ-013 abort SHALL, from any state, go to IDLE on the next edge, clear D, pat_len, position, match_count; no done or match_valid SHALL issue that cycle; abort has priority over simultaneous handshakes.
REQ-014 Text chars with a txt_valid gap SHALL leave D and position unchanged.

Reset
REQ-015 reset low SHALL asynchronously force IDLE, D=0, pat_len=0, position=0, match_count=0, match_pos=0, match_valid=0, done=0, pat_err=0, busy=0; pattern storage contents need not be cleared.
REQ-016 Deassertion SHALL be synchronised externally; first handshake is accepted on the first rising edge after release.

Structure
REQ-017 A shared package SHALL hold the FSM state encoding and the default WILDCARD constant.
REQ-018 One sub-module, pe_cmp_cell (registered pattern char, wildcard compare, D bit), SHALL be instantiated PAT_MAX times via generate.

Verification
REQ-019 Pattern "ab", text "xabab" (last on 'b') -> match_valid at positions 2 and 4, match_count=2, done one cycle after last handshake.
REQ-020 Pattern "aa", text "aaaa" -> matches at 1,2,3 on consecutive cycles, match_count=3.
REQ-021 Pattern "a?c", wildcard_en=1, text "abcazc" -> matches at 2,5; same with wildcard_en=0 -> no match, count 0.
REQ-022 Load 18 chars with PAT_MAX=16 -> pat_err=1, pat_len=16, first 16 chars used for matching.
REQ-023 abort mid-SCAN after "xa" of pattern "ab" -> IDLE next edge, no done; reload "ab", text "b" -> no match (D cleared).
REQ-024 reset low mid-SCAN with txt_valid held high -> all outputs at reset values immediately, txt_ready=0 until new pattern loaded.

Source files
------------

// File: rtl/pattern_scan_array_pkg.sv
// Shared definitions for the pattern scan array: FSM state encoding and the
// default don't-care character.
package pattern_scan_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0] WILDCARD_DEFAULT = 8'h3F;

endpackage

// File: rtl/pattern_scan_array_pe_cmp_cell.sv
// One shift-and processing element: holds one pattern character and the
// matching D bit for that pattern position.
module pe_cmp_cell
    import pattern_scan_array_pkg::*;
#(
    parameter int                 DWIDTH   = 8,
    parameter logic [DWIDTH-1:0]  WILDCARD = DWIDTH'(WILDCARD_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DWIDTH-1:0] load_char_i,
    input  logic              active_i,
    input  logic              wc_en_i,
    input  logic              step_i,
    input  logic [DWIDTH-1:0] txt_char_i,
    input  logic              d_prev_i,
    output logic              d_next_o,
    output logic              d_o
);

    logic [DWIDTH-1:0] pat_q;
    logic              d_q;
    logic              eq_s;

    // Character compare with optional don't-care
    always_comb begin
        eq_s = active_i & ((pat_q == txt_char_i) | (wc_en_i & (pat_q == WILDCARD)));
    end

    assign d_next_o = d_prev_i & eq_s;
    assign d_o      = d_q;

    // Pattern character storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
        end else if (load_i) begin
            pat_q <= load_char_i;
        end
    end

    // D bit advances only on an accepted text character
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else if (clear_i) begin
            d_q <= 1'b0;
        end else if (step_i) begin
            d_q <= d_next_o;
        end
    end

endmodule

// File: rtl/pattern_scan_array.sv
// Streaming pattern matcher: loads a pattern, then scans text with a
// shift-and cell array, reporting every (overlapping) match position.
module pattern_scan_array
    import pattern_scan_array_pkg::*;
#(
    parameter int                DWIDTH   = 8,
    parameter int                PAT_MAX  = 16,
    parameter int                POS_W    = 16,
    parameter logic [DWIDTH-1:0] WILDCARD = DWIDTH'(WILDCARD_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              wildcard_en,
    input  logic              pat_valid,
    output logic              pat_ready,
    input  logic [DWIDTH-1:0] pat_char,
    input  logic              pat_last,
    input  logic              txt_valid,
    output logic              txt_ready,
    input  logic [DWIDTH-1:0] txt_char,
    input  logic              txt_last,
    output logic              match_valid,
    output logic [POS_W-1:0]  match_pos,
    output logic [POS_W-1:0]  match_count,
    output logic              pat_err,
    output logic              busy,
    output logic              done
);

    localparam int               LEN_W   = $clog2(PAT_MAX + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_MAX);
    localparam logic [POS_W-1:0] POS_MAX = '1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   pat_len_q;
    logic [POS_W-1:0]   pos_q, match_pos_q, match_count_q;
    logic               match_valid_q, pat_err_q, wc_q;
    logic               pat_hs_s, txt_hs_s, hit_s, clear_s, step_s;
    logic [PAT_MAX-1:0] d_s, d_next_s, active_s, load_s, tail_s;
    logic               d_top_unused_s;

    assign pat_hs_s = pat_valid & pat_ready;
    assign txt_hs_s = txt_valid & txt_ready;
    assign step_s   = txt_hs_s & ~abort;
    assign clear_s  = abort | (state_q != ST_SCAN);
    assign hit_s    = |(d_next_s & tail_s);
    assign d_top_unused_s = d_s[PAT_MAX-1];

    for (genvar g = 0; g < PAT_MAX; g++) begin : g_cell
        logic prev_s;
        if (g == 0) begin : g_first
            assign prev_s = 1'b1;
        end else begin : g_rest
            assign prev_s = d_s[g-1];
        end
        assign active_s[g] = (LEN_W'(g) < pat_len_q);
        assign tail_s[g]   = (pat_len_q == LEN_W'(g + 1));
        assign load_s[g]   = pat_hs_s & ~abort & (pat_len_q == LEN_W'(g));

        pe_cmp_cell #(
            .DWIDTH   (DWIDTH),
            .WILDCARD (WILDCARD)
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .clear_i     (clear_s),
            .load_i      (load_s[g]),
            .load_char_i (pat_char),
            .active_i    (active_s[g]),
            .wc_en_i     (wc_q),
            .step_i      (step_s),
            .txt_char_i  (txt_char),
            .d_prev_i    (prev_s),
            .d_next_o    (d_next_s[g]),
            .d_o         (d_s[g])
        );
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; abort wins over any handshake
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pat_hs_s) begin
                        state_d = pat_last ? ST_SCAN : ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (pat_hs_s && pat_last) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_SCAN: begin
                    if (txt_hs_s && txt_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the state register
    always_comb begin
        pat_ready = 1'b0;
        txt_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pat_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD: pat_ready = 1'b1;
            ST_SCAN: txt_ready = 1'b1;
            ST_DONE: done      = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Pattern length, text position, match reporting and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_len_q     <= '0;
            pos_q         <= '0;
            match_pos_q   <= '0;
            match_count_q <= '0;
            match_valid_q <= 1'b0;
            pat_err_q     <= 1'b0;
            wc_q          <= 1'b0;
        end else if (abort) begin
            pat_len_q     <= '0;
            pos_q         <= '0;
            match_count_q <= '0;
            match_valid_q <= 1'b0;
        end else begin
            match_valid_q <= 1'b0;
            if (pat_hs_s) begin
                if (pat_len_q != LEN_MAX) begin
                    pat_len_q <= pat_len_q + LEN_W'(1);
                end
                if (state_q == ST_IDLE) begin
                    pat_err_q <= 1'b0;
                end else if (pat_len_q == LEN_MAX) begin
                    pat_err_q <= 1'b1;
                end
                if (pat_last) begin
                    wc_q          <= wildcard_en;
                    pos_q         <= '0;
                    match_count_q <= '0;
                end
            end
            if (txt_hs_s) begin
                pos_q <= (pos_q == POS_MAX) ? pos_q : pos_q + POS_W'(1);
                if (hit_s) begin
                    match_valid_q <= 1'b1;
                    match_pos_q   <= pos_q;
                    match_count_q <= (match_count_q == POS_MAX) ? match_count_q
                                                                : match_count_q + POS_W'(1);
                end
            end
            // A finished scan leaves the pattern length ready for a fresh load
            if (state_q == ST_DONE) begin
                pat_len_q <= '0;
            end
        end
    end

    assign match_valid = match_valid_q;
    assign match_pos   = match_pos_q;
    assign match_count = match_count_q;
    assign pat_err     = pat_err_q;

endmodule

// File: tb/tb_pattern_scan_array.sv
// Randomised and directed bench for pattern_scan_array, checked every cycle
// against a sliding-window string-compare model.
module tb_pattern_scan_array;

    localparam int PM = 16;

    logic       clk = 1'b0, reset = 1'b0, abort = 1'b0, wildcard_en = 1'b0;
    logic       pat_valid = 1'b0, pat_last = 1'b0, txt_valid = 1'b0, txt_last = 1'b0;
    logic [7:0] pat_char = 8'h00, txt_char = 8'h00;
    logic       pat_ready, txt_ready, match_valid, pat_err, busy, done;
    logic [15:0] match_pos, match_count;

    pattern_scan_array dut (
        .clk(clk), .reset(reset), .abort(abort), .wildcard_en(wildcard_en),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_char(pat_char), .pat_last(pat_last),
        .txt_valid(txt_valid), .txt_ready(txt_ready), .txt_char(txt_char), .txt_last(txt_last),
        .match_valid(match_valid), .match_pos(match_pos), .match_count(match_count),
        .pat_err(pat_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0;
    int mlog[$], mcyc[$];

    // model state: 0 idle, 1 load, 2 scan, 3 done
    int         m_phase, m_plen, m_pos, m_cnt, e_pos;
    logic [7:0] m_pat [PM];
    logic [7:0] m_hist[$];
    bit         m_err, m_wc, e_mv, mon_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void model_init();
        m_phase = 0; m_plen = 0; m_pos = 0; m_cnt = 0; m_err = 1'b0; m_wc = 1'b0;
        e_mv = 1'b0; e_pos = 0; m_hist.delete();
    endfunction

    function automatic bit win_match();
        int base;
        if (m_plen == 0 || m_hist.size() < m_plen) return 1'b0;
        base = m_hist.size() - m_plen;
        for (int j = 0; j < m_plen; j++) begin
            if (!((m_hist[base + j] == m_pat[j]) || (m_wc && m_pat[j] == 8'h3F))) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step();
        e_mv = 1'b0;
        if (abort) begin
            m_phase = 0; m_plen = 0; m_pos = 0; m_cnt = 0; m_hist.delete();
            return;
        end
        case (m_phase)
            0, 1: if (pat_valid) begin
                if (m_phase == 0) m_err = 1'b0;
                if (m_plen < PM) begin
                    m_pat[m_plen] = pat_char;
                    m_plen++;
                end else begin
                    m_err = 1'b1;
                end
                if (pat_last) begin
                    m_wc = wildcard_en; m_phase = 2; m_pos = 0; m_cnt = 0; m_hist.delete();
                end else begin
                    m_phase = 1;
                end
            end
            2: if (txt_valid) begin
                m_hist.push_back(txt_char);
                if (win_match()) begin
                    e_mv = 1'b1; e_pos = m_pos;
                    if (m_cnt < 65535) m_cnt++;
                end
                if (m_pos < 65535) m_pos++;
                if (txt_last) m_phase = 3;
            end
            default: begin
                m_phase = 0; m_plen = 0;
            end
        endcase
    endfunction

    // Compare DUT against the model, then advance the model over the coming edge
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("match_valid", match_valid, e_mv);
            if (e_mv) chk("match_pos", match_pos, e_pos);
            chk("match_count", match_count, m_cnt);
            chk("done", done, m_phase == 3);
            chk("busy", busy, m_phase != 0);
            chk("pat_ready", pat_ready, m_phase <= 1);
            chk("txt_ready", txt_ready, m_phase == 2);
            chk("pat_err", pat_err, m_err);
            if (match_valid) begin
                mlog.push_back(int'(match_pos));
                mcyc.push_back(cyc);
            end
            if (done) done_cnt++;
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(bit is_txt);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (is_txt ? txt_ready : pat_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pat(logic [7:0] c, bit last, bit wc);
        pat_valid = 1'b1; pat_char = c; pat_last = last; wildcard_en = wc;
        wait_rdy(1'b0);
        pat_valid = 1'b0; pat_last = 1'b0;
    endtask

    task automatic send_txt(logic [7:0] c, bit last);
        txt_valid = 1'b1; txt_char = c; txt_last = last;
        wait_rdy(1'b1);
        txt_valid = 1'b0; txt_last = 1'b0;
    endtask

    task automatic load_str(string s, bit wc);
        for (int i = 0; i < s.len(); i++) send_pat(s[i], i == s.len() - 1, wc);
    endtask

    task automatic scan_str(string s, int gapmax);
        for (int i = 0; i < s.len(); i++) begin
            send_txt(s[i], i == s.len() - 1);
            repeat ($urandom_range(0, gapmax)) tick();
        end
        repeat (3) tick();
    endtask

    task automatic clr_log();
        mlog.delete(); mcyc.delete(); done_cnt = 0;
    endtask

    task automatic chk_log(string n, int n_exp, int e [4]);
        chk({n, "_nmatch"}, mlog.size(), n_exp);
        for (int i = 0; i < n_exp && i < mlog.size(); i++) chk({n, "_pos"}, mlog[i], e[i]);
    endtask

    string alpha = "ab?";

    initial begin
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_match_valid", match_valid, 1'b0);
        chk("rst_match_count", match_count, 16'd0);
        chk("rst_match_pos", match_pos, 16'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_txt_ready", txt_ready, 1'b0);
        #20;
        tick();
        reset = 1'b1;
        model_init();
        mon_en = 1'b1;
        tick();

        clr_log(); load_str("ab", 1'b0); scan_str("xabab", 1);
        chk_log("ab_xabab", 2, '{2, 4, 0, 0});
        chk("ab_count", match_count, 16'd2);
        chk("ab_done_pulses", done_cnt, 1);

        clr_log(); load_str("aa", 1'b0); scan_str("aaaa", 0);
        chk_log("aa_aaaa", 3, '{1, 2, 3, 0});
        chk("aa_count", match_count, 16'd3);
        if (mcyc.size() == 3) chk("aa_consecutive", mcyc[2] - mcyc[0], 2);

        clr_log(); load_str("a?c", 1'b1); scan_str("abcazc", 1);
        chk_log("wc_on", 2, '{2, 5, 0, 0});
        clr_log(); load_str("a?c", 1'b0); scan_str("abcazc", 1);
        chk_log("wc_off", 0, '{0, 0, 0, 0});
        chk("wc_off_count", match_count, 16'd0);

        clr_log(); load_str("abcdefghijklmnopqr", 1'b0);
        chk("ovf_pat_err", pat_err, 1'b1);
        scan_str("zabcdefghijklmnop", 0);
        chk_log("ovf", 1, '{16, 0, 0, 0});

        clr_log(); load_str("ab", 1'b0);
        send_txt("x", 1'b0); send_txt("a", 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        load_str("ab", 1'b0); scan_str("b", 0);
        chk_log("abort_reload", 0, '{0, 0, 0, 0});
        chk("abort_done_pulses", done_cnt, 1);

        for (int it = 0; it < 40; it++) begin
            int  pl = $urandom_range(1, 5);
            int  tl = $urandom_range(1, 20);
            bit  wc = 1'($urandom_range(0, 1));
            int  ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, tl - 1) : -1;
            for (int i = 0; i < pl; i++) send_pat(alpha[$urandom_range(0, 2)], i == pl - 1, wc);
            for (int i = 0; i < tl; i++) begin
                if (i == ab) begin
                    abort = 1'b1; tick(); abort = 1'b0;
                    break;
                end
                send_txt(($urandom_range(0, 1) == 0) ? 8'h61 : 8'h62, i == tl - 1);
                repeat ($urandom_range(0, 1)) tick();
            end
            repeat (2) tick();
        end

        load_str("ab", 1'b0);
        send_txt("a", 1'b0);
        txt_valid = 1'b1; txt_char = "b";
        #2;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_txt_ready", txt_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_match_count", match_count, 16'd0);
        chk("mid_rst_match_valid", match_valid, 1'b0);
        chk("mid_rst_pat_ready", pat_ready, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_txt_ready", txt_ready, 1'b0);
        end
        tick();
        txt_valid = 1'b0;
        model_init();
        mon_en = 1'b1;
        clr_log(); load_str("ba", 1'b0); scan_str("bba", 0);
        chk_log("post_rst", 1, '{2, 0, 0, 0});

        repeat (2) tick();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
